// File: rtl/conv_event_scatter_pkg.sv
// Shared types, kernel constants and helpers for the event-driven 3x3 convolution scatter.
// Latency: n/a (package of combinational helpers).
// Backpressure: n/a.
package conv_event_scatter_pkg;

    localparam int COORD_BITS  = 8;
    localparam int IMG_WIDTH   = 32;
    localparam int IMG_HEIGHT  = 32;
    localparam int CHANNELS    = 1;
    localparam int NEURON_BITS = 9;
    localparam int KERNEL_BITS = 6;
    localparam int ADDR_BITS   = $clog2(IMG_WIDTH * IMG_HEIGHT);
    localparam int KPOS        = 9;

    localparam logic [3:0] K_LAST = 4'd8;

    // Coordinate as carried on in_coord: x in the upper half.
    typedef struct packed {
        logic [COORD_BITS-1:0] x;
        logic [COORD_BITS-1:0] y;
    } vec2_t;

    // One bit wider than a coordinate so that x-1 of x=0 is representable.
    typedef logic signed [COORD_BITS:0]  scoord_t;
    typedef logic signed [KERNEL_BITS-1:0] kw_t;
    typedef logic [CHANNELS*NEURON_BITS-1:0] nvec_t;

    typedef struct packed {
        scoord_t dx;
        scoord_t dy;
    } offset_t;

    // Vertical-gradient kernel, replicated across channels.
    localparam kw_t kernel_weights [KPOS][CHANNELS] = '{
        '{default: kw_t'(1)},  '{default: kw_t'(2)},  '{default: kw_t'(1)},
        '{default: kw_t'(0)},  '{default: kw_t'(0)},  '{default: kw_t'(0)},
        '{default: kw_t'(-1)}, '{default: kw_t'(-2)}, '{default: kw_t'(-1)}
    };

    function automatic logic [2*COORD_BITS-1:0] pack_coord(input logic [COORD_BITS-1:0] x,
                                                           input logic [COORD_BITS-1:0] y);
        return {x, y};
    endfunction

    function automatic vec2_t unpack_coord(input logic [2*COORD_BITS-1:0] raw);
        return vec2_t'(raw);
    endfunction

    // Kernel position k -> neighbour offset; kx = k%3, ky = k/3, both centred on zero.
    function automatic offset_t kernel_offset(input logic [3:0] k);
        offset_t o;
        case (k)
            4'd0, 4'd3, 4'd6: o.dx = scoord_t'(-1);
            4'd1, 4'd4, 4'd7: o.dx = scoord_t'(0);
            default:          o.dx = scoord_t'(1);
        endcase
        if (k < 4'd3)      o.dy = scoord_t'(-1);
        else if (k < 4'd6) o.dy = scoord_t'(0);
        else               o.dy = scoord_t'(1);
        return o;
    endfunction

    // A location is on the map when both coordinates are non-negative and below the limits.
    function automatic logic xy_in_bounds(input scoord_t x, input scoord_t y);
        return !x[COORD_BITS] && (x < scoord_t'(IMG_WIDTH)) &&
               !y[COORD_BITS] && (y < scoord_t'(IMG_HEIGHT));
    endfunction

    // Add kernel position k's weight to every channel, clamping to the neuron range.
    function automatic nvec_t apply_kernel_weights(input nvec_t rd, input logic [3:0] k);
        localparam logic signed [NEURON_BITS:0] NMAX = (NEURON_BITS+1)'((1 << (NEURON_BITS-1)) - 1);
        localparam logic signed [NEURON_BITS:0] NMIN = (NEURON_BITS+1)'(-(1 << (NEURON_BITS-1)));
        nvec_t res;
        logic signed [NEURON_BITS-1:0] a;
        logic signed [NEURON_BITS:0]   s;
        kw_t w;
        res = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            a = rd[c*NEURON_BITS +: NEURON_BITS];
            w = kernel_weights[k][c];
            s = {a[NEURON_BITS-1], a} + {{(NEURON_BITS+1-KERNEL_BITS){w[KERNEL_BITS-1]}}, w};
            if (s > NMAX)      s = NMAX;
            else if (s < NMIN) s = NMIN;
            res[c*NEURON_BITS +: NEURON_BITS] = s[NEURON_BITS-1:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/conv_event_scatter_addr_gen.sv
// Maps latched event coordinate plus kernel position to a neighbour address and bounds flag.
// Latency: combinational.
// Backpressure: none; consumer ignores the address when in_bounds is low.
module conv_kernel_addr_gen
    import conv_event_scatter_pkg::*;
(
    input  logic [2*COORD_BITS-1:0] coord,
    input  logic [3:0]              k,
    output logic                    in_bounds,
    output logic [ADDR_BITS-1:0]    addr
);

    vec2_t   c;
    offset_t off;
    scoord_t tx;
    scoord_t ty;

    // Target location and row-major address of the neighbour for position k.
    always_comb begin
        c         = unpack_coord(coord);
        off       = kernel_offset(k);
        tx        = scoord_t'({1'b0, c.x}) + off.dx;
        ty        = scoord_t'({1'b0, c.y}) + off.dy;
        in_bounds = xy_in_bounds(tx, ty);
        addr      = ADDR_BITS'(ty) * ADDR_BITS'(IMG_WIDTH) + ADDR_BITS'(tx);
    end

endmodule

// File: rtl/conv_event_scatter.sv
// Scatters each spike event's 3x3 kernel into the membrane map by read-modify-write.
// Latency: 2 cycles per on-map neighbour, 1 per off-map one (interior 18, corner 13).
// Backpressure: in_ready low for the whole event; dropped (off-map) events cost no stall.
module conv_event_scatter
    import conv_event_scatter_pkg::*;
(
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [2*COORD_BITS-1:0]         in_coord,
    output logic                            mem_rd_en,
    output logic [ADDR_BITS-1:0]            mem_rd_addr,
    input  logic [CHANNELS*NEURON_BITS-1:0] mem_rd_data,
    output logic                            mem_wr_en,
    output logic [ADDR_BITS-1:0]            mem_wr_addr,
    output logic [CHANNELS*NEURON_BITS-1:0] mem_wr_data,
    output logic                            busy,
    output logic [15:0]                     events_done,
    output logic [15:0]                     events_dropped
);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_UPDATE} state_t;

    state_t                  state;
    vec2_t                   coord_q;
    logic [3:0]              k_q;
    logic [ADDR_BITS-1:0]    addr_q;
    logic                    tgt_in_bounds;
    logic [ADDR_BITS-1:0]    tgt_addr;
    vec2_t                   in_vec;
    logic                    accept;
    logic                    in_range;

    assign in_vec   = unpack_coord(in_coord);
    assign accept   = in_valid && in_ready;
    assign in_range = xy_in_bounds(scoord_t'({1'b0, in_vec.x}), scoord_t'({1'b0, in_vec.y}));

    conv_kernel_addr_gen u_addr_gen (
        .coord     (coord_q),
        .k         (k_q),
        .in_bounds (tgt_in_bounds),
        .addr      (tgt_addr)
    );

    // Strobes follow the state directly so a reset drops them without waiting for a clock.
    assign mem_rd_en   = (state == S_READ) && tgt_in_bounds;
    assign mem_rd_addr = mem_rd_en ? tgt_addr : '0;
    assign mem_wr_en   = (state == S_UPDATE);
    assign mem_wr_addr = mem_wr_en ? addr_q : '0;
    assign mem_wr_data = mem_wr_en ? apply_kernel_weights(mem_rd_data, k_q) : '0;

    // Event sequencer: accept, walk the nine kernel positions, count outcomes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_IDLE;
            coord_q        <= '0;
            k_q            <= '0;
            addr_q         <= '0;
            in_ready       <= 1'b0;
            busy           <= 1'b0;
            events_done    <= '0;
            events_dropped <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    in_ready <= 1'b1;
                    if (accept) begin
                        coord_q <= in_vec;
                        if (!in_range) begin
                            events_dropped <= events_dropped + 16'd1;
                        end else begin
                            k_q      <= '0;
                            state    <= S_READ;
                            busy     <= 1'b1;
                            in_ready <= 1'b0;
                        end
                    end
                end
                S_READ: begin
                    if (tgt_in_bounds) begin
                        addr_q <= tgt_addr;
                        state  <= S_UPDATE;
                    end else if (k_q == K_LAST) begin
                        state       <= S_IDLE;
                        busy        <= 1'b0;
                        in_ready    <= 1'b1;
                        events_done <= events_done + 16'd1;
                    end else begin
                        k_q <= k_q + 4'd1;
                    end
                end
                S_UPDATE: begin
                    if (k_q == K_LAST) begin
                        state       <= S_IDLE;
                        busy        <= 1'b0;
                        in_ready    <= 1'b1;
                        events_done <= events_done + 16'd1;
                    end else begin
                        k_q   <= k_q + 4'd1;
                        state <= S_READ;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_conv_event_scatter.sv
// Directed bench for conv_event_scatter with an external map model and an access-stream model.
// Latency: n/a.
// Backpressure: waits on in_ready with a bounded cycle budget.
module tb_conv_event_scatter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_coord = '0;
    logic        mem_rd_en;
    logic [9:0]  mem_rd_addr;
    logic [8:0]  mem_rd_data = '0;
    logic        mem_wr_en;
    logic [9:0]  mem_wr_addr;
    logic [8:0]  mem_wr_data;
    logic        busy;
    logic [15:0] events_done;
    logic [15:0] events_dropped;

    conv_event_scatter dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_coord       (in_coord),
        .mem_rd_en      (mem_rd_en),
        .mem_rd_addr    (mem_rd_addr),
        .mem_rd_data    (mem_rd_data),
        .mem_wr_en      (mem_wr_en),
        .mem_wr_addr    (mem_wr_addr),
        .mem_wr_data    (mem_wr_data),
        .busy           (busy),
        .events_done    (events_done),
        .events_dropped (events_dropped)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    logic [8:0] mem [1024];   // the feature-map memory the DUT talks to
    int ref_mem [1024];       // model's expected map contents
    int exp_rd_q[$];
    int exp_wr_addr_q[$];
    int exp_wr_w_q[$];
    int W [9] = '{1, 2, 1, 0, 0, 0, -1, -2, -1};
    int exp_done = 0;
    int exp_dropped = 0;

    task automatic check(input string name, input int actual, input int expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    function automatic int s9(input logic [8:0] v);
        return int'($signed(v));
    endfunction

    function automatic int sat9(input int v);
        if (v > 255) return 255;
        if (v < -256) return -256;
        return v;
    endfunction

    task automatic clear_maps();
        for (int i = 0; i < 1024; i++) begin
            mem[i] = '0;
            ref_mem[i] = 0;
        end
    endtask

    task automatic preload(input int a, input int v);
        mem[a] = 9'(v);
        ref_mem[a] = v;
    endtask

    // Expected access stream of one event: every on-map neighbour in kernel order.
    task automatic push_model(input int x, input int y);
        int tx;
        int ty;
        for (int k = 0; k < 9; k++) begin
            tx = x + (k % 3) - 1;
            ty = y + (k / 3) - 1;
            if (tx >= 0 && tx < 32 && ty >= 0 && ty < 32) begin
                exp_rd_q.push_back(ty * 32 + tx);
                exp_wr_addr_q.push_back(ty * 32 + tx);
                exp_wr_w_q.push_back(W[k]);
            end
        end
    endtask

    // External memory: read data lands mid-READ and holds through UPDATE.
    always @(negedge clk) begin
        if (mem_wr_en) mem[mem_wr_addr] = mem_wr_data;
        if (mem_rd_en) mem_rd_data = mem[mem_rd_addr];
    end

    // Compare process: every strobe must match the next expected access.
    always @(negedge clk) begin
        int a;
        int w;
        int e;
        if (rst_n) begin
            if (mem_rd_en) begin
                if (exp_rd_q.size() == 0) check("unexpected_read", int'(mem_rd_addr), -1);
                else check("rd_addr", int'(mem_rd_addr), exp_rd_q.pop_front());
            end
            if (mem_wr_en) begin
                if (exp_wr_addr_q.size() == 0) begin
                    check("unexpected_write", int'(mem_wr_addr), -1);
                end else begin
                    a = exp_wr_addr_q.pop_front();
                    w = exp_wr_w_q.pop_front();
                    e = sat9(ref_mem[a] + w);
                    ref_mem[a] = e;
                    check("wr_addr", int'(mem_wr_addr), a);
                    check("wr_data", s9(mem_wr_data), e);
                end
            end
        end
    end

    task automatic send_event(input int x, input int y, output int busy_cycles);
        int n;
        int rdy_while_busy;
        n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("in_ready_timeout", 0, 1);
        in_valid = 1'b1;
        in_coord = {8'(x), 8'(y)};
        if (x < 32 && y < 32) begin
            push_model(x, y);
            exp_done++;
        end else begin
            exp_dropped++;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        busy_cycles = 0;
        rdy_while_busy = 0;
        while (busy_cycles < 100) begin
            @(negedge clk);
            if (!busy) break;
            busy_cycles++;
            if (in_ready) rdy_while_busy++;
        end
        check("in_ready_while_busy", rdy_while_busy, 0);
        check("in_ready_after", int'(in_ready), 1);
        check("events_done", int'(events_done), exp_done);
        check("events_dropped", int'(events_dropped), exp_dropped);
        check("pending_writes", exp_wr_addr_q.size(), 0);
    endtask

    int lit_addr [9] = '{132, 133, 134, 164, 165, 166, 196, 197, 198};
    int lit_val  [9] = '{1, 2, 1, 0, 0, 0, -1, -2, -1};

    initial begin
        int n;
        int n2;
        clear_maps();
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", int'(in_ready), 0);
        check("rst_rd_en", int'(mem_rd_en), 0);
        check("rst_wr_en", int'(mem_wr_en), 0);
        check("rst_rd_addr", int'(mem_rd_addr), 0);
        check("rst_wr_addr", int'(mem_wr_addr), 0);
        check("rst_wr_data", int'(mem_wr_data), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(events_done), 0);
        check("rst_dropped", int'(events_dropped), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("ready_after_release", int'(in_ready), 1);

        // Interior event on a zeroed map.
        send_event(5, 5, n);
        check("interior_cycles", n, 18);
        for (int i = 0; i < 9; i++) check("interior_map", s9(mem[lit_addr[i]]), lit_val[i]);
        check("interior_done_lit", int'(events_done), 1);

        // Top-left corner: only four neighbours on the map.
        send_event(0, 0, n);
        check("corner_cycles", n, 13);
        check("corner_map0", s9(mem[0]), 0);
        check("corner_map1", s9(mem[1]), 0);
        check("corner_map32", s9(mem[32]), -2);
        check("corner_map33", s9(mem[33]), -1);

        // Saturation at both ends.
        clear_maps();
        preload(133, 255);
        preload(197, -256);
        send_event(5, 5, n);
        check("sat_pos", s9(mem[133]), 255);
        check("sat_neg", s9(mem[197]), -256);

        // Bottom-right corner then an off-map event back-to-back.
        clear_maps();
        send_event(31, 31, n);
        check("br_cycles", n, 13);
        check("br_map990", s9(mem[990]), 1);
        check("br_map1023", s9(mem[1023]), 0);
        send_event(40, 3, n2);
        check("drop_cycles", n2, 0);
        check("drop_count_lit", int'(events_dropped), 1);

        // Two overlapping events accumulate.
        clear_maps();
        send_event(5, 5, n);
        send_event(6, 5, n);
        check("accum_134", s9(mem[134]), 3);
        check("accum_166", s9(mem[166]), 0);

        // Reset during the fifth kernel position of an interior event.
        clear_maps();
        in_valid = 1'b1;
        in_coord = {8'd5, 8'd5};
        push_model(5, 5);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        #2;
        check("rd_before_reset", int'(mem_rd_en), 1);
        check("writes_before_reset", 9 - exp_wr_addr_q.size(), 4);
        rst_n = 1'b0;
        #1;
        check("midrst_rd_en", int'(mem_rd_en), 0);
        check("midrst_wr_en", int'(mem_wr_en), 0);
        check("midrst_busy", int'(busy), 0);
        exp_rd_q.delete();
        exp_wr_addr_q.delete();
        exp_wr_w_q.delete();
        exp_done = 0;
        exp_dropped = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("postrst_ready", int'(in_ready), 1);
        check("postrst_done", int'(events_done), 0);
        check("postrst_dropped", int'(events_dropped), 0);
        send_event(2, 2, n);
        check("postrst_cycles", n, 18);
        check("postrst_map34", s9(mem[34]), 2);
        check("postrst_partial132", s9(mem[132]), 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
